// File: rtl/song_sequencer_pkg.sv
// Shared encodings for the song sequencer: FSM state codes and the note-code
// table used by both the pattern ROM contents and the tone generator voices.
package song_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_FETCH     = 2'd2,
        ST_ISSUE     = 2'd3
    } seq_state_t;

    // Code 0 silences a voice; the rest index the tone generator's pitch table.
    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C    = 4'd1;
    localparam logic [3:0] NOTE_D    = 4'd2;
    localparam logic [3:0] NOTE_E    = 4'd3;
    localparam logic [3:0] NOTE_F    = 4'd4;
    localparam logic [3:0] NOTE_G    = 4'd5;
    localparam logic [3:0] NOTE_A    = 4'd6;
    localparam logic [3:0] NOTE_B    = 4'd7;
    localparam logic [3:0] NOTE_C2   = 4'd8;

    // Width helper that never yields a zero-width vector.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/song_sequencer_step_timer.sv
// Tempo counter: counts sample ticks modulo STEP_SAMPLES and flags the last
// sample of each step.
module step_timer
    import song_sequencer_pkg::*;
#(
    parameter int STEP_SAMPLES = 2048
) (
    input  logic clock,
    input  logic reset,
    input  logic sample_ena,
    input  logic enable,
    input  logic clear,
    output logic step_tick
);

    localparam int CNT_W = safe_clog2(STEP_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_SAMPLES - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && sample_ena) begin
            count_reg <= (count_reg == CNT_MAX) ? '0 : count_reg + 1'b1;
        end
    end

    assign step_tick = sample_ena && (count_reg == CNT_MAX);

endmodule

// File: rtl/song_sequencer.sv
// Pattern-driven note scheduler: fetches one ROM row per tempo step and
// issues it as per-voice note writes over a valid/ready handshake.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int STEP_SAMPLES = 2048,
    parameter int STEPS        = 16,
    parameter int VOICES       = 4,
    parameter int NOTE_W       = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  sample_ena,
    input  logic                                  run,
    output logic [safe_clog2(STEPS)-1:0]          pat_addr,
    input  logic [VOICES*NOTE_W-1:0]              pat_data,
    output logic                                  note_valid,
    output logic [safe_clog2(VOICES)-1:0]         note_voice,
    output logic [NOTE_W-1:0]                     note_code,
    input  logic                                  note_ready,
    output logic                                  step_strobe,
    output logic [safe_clog2(STEPS)-1:0]          step_idx,
    output logic                                  busy,
    output logic                                  overrun
);

    localparam int STEP_W = safe_clog2(STEPS);
    localparam int VOICE_W = safe_clog2(VOICES);
    localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(VOICES - 1);

    seq_state_t                state_reg;
    logic [STEP_W-1:0]         step_reg;
    logic [VOICE_W-1:0]        voice_reg;
    logic [VOICES*NOTE_W-1:0]  row_reg;
    logic                      valid_reg;
    logic                      strobe_reg;
    logic                      overrun_reg;
    logic                      step_tick;
    logic                      timer_clear;
    logic                      timer_enable;
    logic [NOTE_W-1:0]         row_slices [VOICES];

    assign timer_enable = (state_reg != ST_IDLE);
    assign timer_clear  = (state_reg == ST_WAIT_TICK) && !run;

    step_timer #(
        .STEP_SAMPLES(STEP_SAMPLES)
    ) u_step_timer (
        .clock     (clock),
        .reset     (reset),
        .sample_ena(sample_ena),
        .enable    (timer_enable),
        .clear     (timer_clear),
        .step_tick (step_tick)
    );

    generate
        for (genvar gi = 0; gi < VOICES; gi++) begin : g_slice
            assign row_slices[gi] = row_reg[gi*NOTE_W +: NOTE_W];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            step_reg    <= '0;
            voice_reg   <= '0;
            row_reg     <= '0;
            valid_reg   <= 1'b0;
            strobe_reg  <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (run) begin
                        state_reg  <= ST_FETCH;
                        strobe_reg <= 1'b1;
                    end
                end
                ST_WAIT_TICK: begin
                    if (!run) begin
                        state_reg   <= ST_IDLE;
                        step_reg    <= '0;
                        overrun_reg <= 1'b0;
                    end else if (step_tick) begin
                        state_reg  <= ST_FETCH;
                        strobe_reg <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    row_reg    <= pat_data;
                    voice_reg  <= '0;
                    strobe_reg <= 1'b0;
                    valid_reg  <= 1'b1;
                    state_reg  <= ST_ISSUE;
                    if (step_tick) begin
                        overrun_reg <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // A tick here is dropped; the next row waits for the following one.
                    if (step_tick) begin
                        overrun_reg <= 1'b1;
                    end
                    if (valid_reg && note_ready) begin
                        if (voice_reg == LAST_VOICE) begin
                            valid_reg <= 1'b0;
                            step_reg  <= step_reg + 1'b1;
                            state_reg <= ST_WAIT_TICK;
                        end else begin
                            voice_reg <= voice_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign pat_addr    = step_reg;
    assign step_idx    = step_reg;
    assign note_valid  = valid_reg;
    assign note_voice  = voice_reg;
    assign note_code   = row_slices[voice_reg];
    assign step_strobe = strobe_reg;
    assign overrun     = overrun_reg;
    assign busy        = (state_reg == ST_FETCH) || (state_reg == ST_ISSUE);

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: tempo, handshake stalls, loop wrap,
// stop mid-row, overrun and asynchronous reset during note issue.
module tb_song_sequencer;

    localparam int SS = 8;
    localparam int ST = 16;
    localparam int NV = 4;
    localparam int NW = 4;

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        sample_ena;
    logic        run;
    logic        note_ready;
    logic [3:0]  pat_addr;
    logic [15:0] pat_data;
    logic        note_valid;
    logic [1:0]  note_voice;
    logic [3:0]  note_code;
    logic        step_strobe;
    logic [3:0]  step_idx;
    logic        busy;
    logic        overrun;

    logic [15:0] rom [ST];
    int          cyc;
    int          n_cmp = 0;
    int          n_err = 0;
    ev_t         xq[$];
    ev_t         sq[$];

    song_sequencer #(
        .STEP_SAMPLES(SS),
        .STEPS       (ST),
        .VOICES      (NV),
        .NOTE_W      (NW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sample_ena (sample_ena),
        .run        (run),
        .pat_addr   (pat_addr),
        .pat_data   (pat_data),
        .note_valid (note_valid),
        .note_voice (note_voice),
        .note_code  (note_code),
        .note_ready (note_ready),
        .step_strobe(step_strobe),
        .step_idx   (step_idx),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    // Synchronous pattern ROM.
    always @(posedge clock) pat_data <= rom[pat_addr];

    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clock) begin
        ev_t e;
        if (!reset) begin
            if (note_valid && note_ready) begin
                e.cyc = cyc; e.a = int'(note_voice); e.b = int'(note_code);
                xq.push_back(e);
                $display("cyc %0d xfer voice=%0d code=%0d", cyc, note_voice, note_code);
            end
            if (step_strobe) begin
                e.cyc = cyc; e.a = int'(pat_addr); e.b = 0;
                sq.push_back(e);
                $display("cyc %0d fetch addr=%0d", cyc, pat_addr);
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int slice(input int s, input int v);
        logic [15:0] r;
        r = rom[s % ST];
        return int'((r >> (4 * v)) & 16'hF);
    endfunction

    task automatic at_cycle(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic at_neg(input int n);
        at_cycle(n);
        @(negedge clock);
    endtask

    // Expected transfer at index i: cycle, voice, code.
    task automatic check_xfer(input int i, input int c, input int v, input int code);
        if (i < xq.size()) begin
            check("xfer_cyc", xq[i].cyc, c);
            check("xfer_voice", xq[i].a, v);
            check("xfer_code", xq[i].b, code);
        end
    endtask

    task automatic check_fetch(input int i, input int c, input int addr);
        if (i < sq.size()) begin
            check("fetch_cyc", sq[i].cyc, c);
            check("fetch_addr", sq[i].a, addr);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rom[0] = 16'h5432;
        for (int i = 1; i < ST; i++) rom[i] = 16'((i * 3911 + 4132) & 16'hFFFF);
        reset = 1'b1; run = 1'b0; sample_ena = 1'b1; note_ready = 1'b1;
        #3;
        check("rst_valid", int'(note_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_strobe", int'(step_strobe), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_step", int'(step_idx), 0);
        check("rst_addr", int'(pat_addr), 0);
        #19;
        reset = 1'b0;

        // Free-running play: first row fetched without waiting, then every 8 ticks.
        at_cycle(10); run = 1'b1;
        at_neg(16);
        check("step_after_row0", int'(step_idx), 1);
        at_neg(136);
        check("step_wrap", int'(step_idx), 0);
        at_neg(146);
        check("fetch_count_a", sq.size(), 17);
        for (int k = 0; k < 17; k++) check_fetch(k, 11 + 8 * k, k % ST);
        check("xfer_count_a", xq.size(), 68);
        check_xfer(0, 12, 0, 2);
        check_xfer(1, 13, 1, 3);
        check_xfer(2, 14, 2, 4);
        check_xfer(3, 15, 3, 5);
        for (int k = 0; k < 17; k++)
            for (int v = 0; v < NV; v++)
                check_xfer(4 * k + v, 12 + 8 * k + v, v, slice(k, v));
        check("overrun_a", int'(overrun), 0);
        xq.delete(); sq.delete();

        // Stop while voice 2 of row 1 is presented: row completes, then idle.
        at_cycle(150); run = 1'b0;
        at_neg(153);
        check("stop_step", int'(step_idx), 0);
        check("stop_busy", int'(busy), 0);
        at_neg(170);
        check("stop_valid", int'(note_valid), 0);
        check("fetch_count_b", sq.size(), 1);
        check_fetch(0, 147, 1);
        check("xfer_count_b", xq.size(), 4);
        for (int v = 0; v < NV; v++) check_xfer(v, 148 + v, v, slice(1, v));
        xq.delete(); sq.delete();

        // Consumer stalls 3 cycles on voice 1 (tempo paused meanwhile).
        at_cycle(180); run = 1'b1;
        at_cycle(183); note_ready = 1'b0; sample_ena = 1'b0;
        for (int c = 183; c < 186; c++) begin
            at_neg(c);
            check("stall_valid", int'(note_valid), 1);
            check("stall_voice", int'(note_voice), 1);
            check("stall_code", int'(note_code), slice(0, 1));
        end
        at_cycle(186); note_ready = 1'b1; sample_ena = 1'b1;
        at_neg(190);
        check("stall_overrun", int'(overrun), 0);
        check("stall_step", int'(step_idx), 1);
        at_neg(193);
        check("xfer_count_c", xq.size(), 4);
        check_xfer(0, 182, 0, slice(0, 0));
        check_xfer(1, 186, 1, slice(0, 1));
        check_xfer(2, 187, 2, slice(0, 2));
        check_xfer(3, 188, 3, slice(0, 3));
        check("fetch_count_c", sq.size(), 2);
        check_fetch(0, 181, 0);
        check_fetch(1, 192, 1);
        at_cycle(198); run = 1'b0;
        at_neg(200);
        check("stop2_busy", int'(busy), 0);
        check("stop2_step", int'(step_idx), 0);
        xq.delete(); sq.delete();

        // Long stall across two step ticks: overrun sticks, ticks dropped.
        at_cycle(210); run = 1'b1;
        at_cycle(211); note_ready = 1'b0;
        at_neg(220);
        check("ovr_set", int'(overrun), 1);
        check("ovr_valid", int'(note_valid), 1);
        check("ovr_voice", int'(note_voice), 0);
        at_cycle(226); note_ready = 1'b1;
        at_neg(236);
        check("ovr_sticky", int'(overrun), 1);
        check("fetch_count_d", sq.size(), 2);
        check_fetch(0, 211, 0);
        check_fetch(1, 235, 1);
        check("xfer_count_d", xq.size(), 4);
        for (int v = 0; v < NV; v++) check_xfer(v, 226 + v, v, slice(0, v));
        at_cycle(241); run = 1'b0;
        at_neg(243);
        check("ovr_cleared", int'(overrun), 0);
        check("ovr_stop_step", int'(step_idx), 0);
        xq.delete(); sq.delete();

        // Asynchronous reset while a note is held in ISSUE.
        at_cycle(250); run = 1'b1;
        at_cycle(251); note_ready = 1'b0;
        at_neg(259);
        check("pre_rst_valid", int'(note_valid), 1);
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_overrun", int'(overrun), 1);
        at_cycle(260); reset = 1'b1;
        #1;
        check("arst_valid", int'(note_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_strobe", int'(step_strobe), 0);
        check("arst_overrun", int'(overrun), 0);
        check("arst_step", int'(step_idx), 0);
        run = 1'b0; note_ready = 1'b1;
        #20;
        reset = 1'b0;
        #40;
        check("post_rst_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Pattern-driven note scheduler for the sound generator voices. It counts sample ticks to derive the step tempo and fetches one pattern row per step from an external pattern ROM. Each row is then issued as per-voice note-code writes over a valid/ready handshake to the voice note registers. It sits between the pattern ROM and the tone generator's note-code inputs.

Parameters:
STEP_SAMPLES, 2048, sample_ena pulses per sequencer step (≥ VOICES+4).
STEPS, 16, pattern rows per loop (power of two).
VOICES, 4, voices per row (power of two, ≥2).
NOTE_W, 4, note-code width; code 0 = rest/silence.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
sample_ena  in  1  one-cycle sample tick
run  in  1  level; 1 = play, 0 = stop
pat_addr  out  clog2(STEPS)  pattern ROM row address (= step_idx)
pat_data  in  VOICES*NOTE_W  row data; voice v at bits [v*NOTE_W +: NOTE_W]
note_valid  out  1  note transfer valid
note_voice  out  clog2(VOICES)  target voice index
note_code  out  NOTE_W  note code for note_voice
note_ready  in  1  consumer accepts when note_valid && note_ready
step_strobe  out  1  one-cycle pulse when a new row is fetched
step_idx  out  clog2(STEPS)  current row
busy  out  1  state is FETCH or ISSUE
overrun  out  1  sticky: a step tick arrived while not in WAIT_TICK

Behaviour:
- Reset: state IDLE, tempo counter 0, step_idx 0, voice index 0, row buffer 0, note_valid 0, step_strobe 0, busy 0, overrun 0. pat_addr is 0 because it equals step_idx.
- Tempo counter counts sample_ena only while state is not IDLE, from 0 to STEP_SAMPLES-1, then wraps to 0.
- step_tick = sample_ena && counter == STEP_SAMPLES-1.
- States: IDLE, WAIT_TICK, FETCH, ISSUE.
- IDLE: if run=1, next state is FETCH. The first row plays without waiting a step.
- WAIT_TICK:
  - if run=0: go to IDLE, clear tempo counter, step_idx and overrun.
  - else if step_tick: go to FETCH.
- FETCH (exactly 1 cycle):
  - pat_data must be valid this cycle. pat_addr has been stable at least one prior cycle, so a synchronous ROM works.
  - Latch pat_data into the row buffer.
  - step_strobe=1 this cycle only.
  - Voice index is set to 0. Next state is ISSUE.
- ISSUE:
  - note_valid=1, note_voice = voice index, note_code = row buffer slice for that voice.
  - note_voice and note_code are stable while note_valid && !note_ready.
  - On a transfer, voice index increments. After voice VOICES-1 transfers:
    - step_idx increments mod STEPS (STEPS-1 wraps to 0);
    - note_valid drops the next cycle;
    - next state is WAIT_TICK.
  - Back-to-back transfers: with note_ready held high, one voice per cycle, VOICES cycles total.
- run=0 during FETCH or ISSUE does not abort. The row completes, then WAIT_TICK processes the stop.
- Overrun:
  - a step_tick in FETCH or ISSUE sets overrun and is dropped;
  - the tempo counter keeps running;
  - the row finishes and the next row waits for the following tick;
  - overrun clears only on reset or on stop (WAIT_TICK with run=0).
- Latency:
  - run rises in IDLE at cycle N: FETCH at N+1, first note_valid at N+2.
  - step_tick in WAIT_TICK at cycle N: FETCH at N+1, note_valid at N+2.
- Asynchronous reset mid-ISSUE: note_valid deasserts immediately. Everything returns to reset values.
- Widths: counter clog2(STEP_SAMPLES) bits. step_idx wraps naturally.

Decomposition:
- Shared package: state encoding constants (IDLE=0, WAIT_TICK=1, FETCH=2, ISSUE=3), the REST code 0, and the note-code constants already used by the tone generator (D, E, F, …), so pattern ROM contents and voices agree.
- One natural sub-module, step_timer: the tempo counter with enable and clear inputs and a step_tick output. The FSM stays in song_sequencer.

Test Plan:
1. STEP_SAMPLES=8, VOICES=4, sample_ena every cycle, note_ready=1, row0=0x5432, run rises at cycle 10. Required: step_strobe at 11; transfers (voice, code) (0,2),(1,3),(2,4),(3,5) at cycles 12–15; step_idx=1 at 16; next step_strobe 8 sample ticks after the step-0 FETCH.
2. note_ready low for 3 cycles while voice 1 is presented. Required: note_voice=1 and code stable; no voice skipped; 4 transfers total.
3. Loop wrap, STEPS=16, run held. Required: after row 15 is issued, step_idx=0; the next step_strobe fetches pat_addr=0.
4. run=0 mid-ISSUE at voice 2. Required: voices 2 and 3 still issued, then IDLE; step_idx=0; no further note_valid.
5. note_ready=0 held for > STEP_SAMPLES ticks. Required: overrun=1 and stays set; the dropped tick causes no extra FETCH; overrun clears after a stop.
6. Reset asserted during ISSUE. Required: note_valid, busy, step_strobe and overrun = 0 the same cycle; step_idx=0; state IDLE.
